mic_buf_seq: RTL and testbench

- Sequencer for one 512x16 simple-dual-port sample buffer that holds one microphone channel.
- Capture: writes 512 consecutive incoming samples through port A.
- Playback: reads a window of rd_len samples starting at a delay offset, modulo 512, through port B, for the delay-and-sum beamformer.
- Handles the RAM's 1-cycle read latency and presents an AXI-style valid/ready stream with backpressure via a 4-entry output FIFO.

---
 rtl/mic_buf_seq_if.sv | 16 +
 rtl/mic_buf_seq.sv | 107 ++++++++++
 tb/tb_mic_buf_seq.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mic_buf_seq_if.sv
// mic_buf_seq_if: capture input stream (s_*) and playback output stream (m_*) of mic_buf_seq
// Ports: s_valid/s_ready/s_data sample input; m_valid/m_ready/m_data/m_last sample output.
// master = stream source/sink outside the sequencer, slave = the sequencer itself.
interface mic_buf_seq_if #(
   parameter int DW = 16
);
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          m_last;
   modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data, m_last);
   modport slave  (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data, m_last);
endinterface

// File: rtl/mic_buf_seq.sv
// mic_buf_seq: capture/playback sequencer for one 2^AW x DW microphone sample buffer
// Ports: clk, rst_n (async, active low); strm carries the capture and playback streams;
//   i_cap_start/i_rd_start/i_rd_offset/i_rd_len/i_abort control; o_busy/o_cap_done/o_rd_done/o_buf_valid status;
//   o_ram_cea/o_ram_ada/o_ram_din write port A, o_ram_ceb/o_ram_adb/i_ram_dout read port B, o_ram_oce tied high.
module mic_buf_seq #(
   parameter int AW     = 9,
   parameter int DW     = 16,
   parameter int FIFO_D = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   mic_buf_seq_if.slave  strm,
   input  logic          i_cap_start,
   input  logic          i_rd_start,
   input  logic [AW-1:0] i_rd_offset,
   input  logic [AW:0]   i_rd_len,
   input  logic          i_abort,
   output logic          o_busy,
   output logic          o_cap_done,
   output logic          o_rd_done,
   output logic          o_buf_valid,
   output logic          o_ram_cea,
   output logic [AW-1:0] o_ram_ada,
   output logic [DW-1:0] o_ram_din,
   output logic          o_ram_ceb,
   output logic [AW-1:0] o_ram_adb,
   output logic          o_ram_oce,
   input  logic [DW-1:0] i_ram_dout
);
   localparam int FW = $clog2(FIFO_D);
   typedef enum logic [1:0] {IDLE, CAPTURE, READ} state_t;
   state_t        r_state, w_next;
   logic [AW-1:0] r_wr_ptr, r_rd_addr;
   logic [AW:0]   r_issue_cnt;
   logic          r_infl, r_infl_last;
   logic [DW-1:0] r_fifo_data [FIFO_D];
   logic          r_fifo_last [FIFO_D];
   logic [FW-1:0] r_head, r_tail;
   logic [FW:0]   r_fcnt, w_occ;
   logic          r_cap_done, r_rd_done, r_buf_valid;
   logic          w_write, w_cap_end, w_issue, w_pop, w_rd_end, w_abort, w_rd_go, w_cap_go;
   always_comb begin
      w_write   = (r_state == CAPTURE) && strm.s_valid;
      w_cap_end = w_write && (r_wr_ptr == '1);
      // FIFO entries plus the read in flight are the credits already spent
      w_occ     = r_fcnt + {{FW{1'b0}}, r_infl};
      w_issue   = (r_state == READ) && (r_issue_cnt != '0) && (w_occ < (FW+1)'(FIFO_D));
      w_pop     = (r_fcnt != '0) && strm.m_ready;
      w_rd_end  = w_pop && r_fifo_last[r_head];
      w_abort   = i_abort && (r_state != IDLE);
      w_cap_go  = (r_state == IDLE) && i_cap_start;
      w_rd_go   = (r_state == IDLE) && !i_cap_start && i_rd_start;
      w_next    = w_cap_go ? CAPTURE :
                  (w_rd_go && (i_rd_len != '0)) ? READ :
                  (w_abort || w_cap_end || w_rd_end) ? IDLE : r_state;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_wr_ptr    <= '0;
         r_rd_addr   <= '0;
         r_issue_cnt <= '0;
         r_infl      <= 1'b0;
         r_infl_last <= 1'b0;
         r_head      <= '0;
         r_tail      <= '0;
         r_fcnt      <= '0;
         r_cap_done  <= 1'b0;
         r_rd_done   <= 1'b0;
         r_buf_valid <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_wr_ptr    <= w_cap_go ? '0 : w_write ? r_wr_ptr + AW'(1) : r_wr_ptr;
         r_buf_valid <= w_cap_go ? 1'b0 : (w_cap_end && !w_abort) ? 1'b1 : r_buf_valid;
         r_cap_done  <= w_cap_end && !w_abort;
         r_rd_done   <= (w_rd_go && (i_rd_len == '0)) || (w_rd_end && !w_abort);
         r_rd_addr   <= w_rd_go ? i_rd_offset : w_issue ? r_rd_addr + AW'(1) : r_rd_addr;
         r_issue_cnt <= w_abort ? '0 : w_rd_go ? i_rd_len : w_issue ? r_issue_cnt - (AW+1)'(1) : r_issue_cnt;
         // RAM data appears one cycle after the read is issued; the last-flag travels alongside
         r_infl      <= w_issue && !w_abort;
         r_infl_last <= r_issue_cnt == (AW+1)'(1);
         r_head      <= w_abort ? '0 : w_pop ? r_head + FW'(1) : r_head;
         r_tail      <= w_abort ? '0 : r_infl ? r_tail + FW'(1) : r_tail;
         r_fcnt      <= w_abort ? '0 : r_fcnt + (FW+1)'(r_infl) - (FW+1)'(w_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (r_infl) begin
         r_fifo_data[r_tail] <= i_ram_dout;
         r_fifo_last[r_tail] <= r_infl_last;
      end
   end
   assign strm.s_ready = r_state == CAPTURE;
   assign strm.m_valid = r_fcnt != '0;
   assign strm.m_data  = (r_fcnt != '0) ? r_fifo_data[r_head] : '0;
   assign strm.m_last  = (r_fcnt != '0) && r_fifo_last[r_head];
   assign o_busy       = r_state != IDLE;
   assign o_cap_done   = r_cap_done;
   assign o_rd_done    = r_rd_done;
   assign o_buf_valid  = r_buf_valid;
   assign o_ram_cea    = w_write;
   assign o_ram_ada    = w_write ? r_wr_ptr : '0;
   assign o_ram_din    = w_write ? strm.s_data : '0;
   assign o_ram_ceb    = w_issue;
   assign o_ram_adb    = w_issue ? r_rd_addr : '0;
   assign o_ram_oce    = 1'b1;
endmodule

// File: tb/tb_mic_buf_seq.sv
// tb_mic_buf_seq: randomized scoreboard bench for mic_buf_seq with a behavioural RAM and buffer model
module tb_mic_buf_seq;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        cap_start, rd_start, abort;
   logic [8:0]  rd_offset;
   logic [9:0]  rd_len;
   logic        busy, cap_done, rd_done, buf_valid;
   logic        ram_cea, ram_ceb, ram_oce;
   logic [8:0]  ram_ada, ram_adb;
   logic [15:0] ram_din, ram_dout;
   logic [15:0] mem [512];
   logic [15:0] ref_mem [512];
   logic [24:0] exp_wr [$];
   logic [8:0]  exp_rd [$];
   logic [16:0] exp_out [$];
   int n_vec = 0, n_err = 0;
   int n_rd_done = 0, n_cap_done = 0, n_hs = 0, outstanding = 0;
   int rd_exp = 0, cap_exp = 0, m_mode = 0;
   mic_buf_seq_if #(.DW(16)) strm ();
   mic_buf_seq #(.AW(9), .DW(16), .FIFO_D(4)) dut (
      .clk(clk), .rst_n(rst_n), .strm(strm),
      .i_cap_start(cap_start), .i_rd_start(rd_start), .i_rd_offset(rd_offset), .i_rd_len(rd_len),
      .i_abort(abort), .o_busy(busy), .o_cap_done(cap_done), .o_rd_done(rd_done), .o_buf_valid(buf_valid),
      .o_ram_cea(ram_cea), .o_ram_ada(ram_ada), .o_ram_din(ram_din),
      .o_ram_ceb(ram_ceb), .o_ram_adb(ram_adb), .o_ram_oce(ram_oce), .i_ram_dout(ram_dout)
   );
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (ram_cea) mem[ram_ada] <= ram_din;
      if (ram_ceb) ram_dout <= mem[ram_adb];
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic miss(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: DUT activity with nothing expected", name);
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic reset_chk(input string name);
      chk({name, "_ctrl"}, {busy, strm.s_ready, strm.m_valid, strm.m_last, ram_cea, ram_ceb,
                            buf_valid, cap_done, rd_done, ram_oce}, 32'h001);
      chk({name, "_bus"}, {ram_ada, ram_din, ram_adb}, 0);
      chk({name, "_mdata"}, strm.m_data, 0);
   endtask
   // scoreboard monitor, sampled on the falling edge
   initial begin
      logic        stall, last_hs;
      logic [17:0] stall_val;
      logic [24:0] w;
      logic [8:0]  a;
      logic [16:0] o;
      stall = 1'b0;
      last_hs = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall = 1'b0;
            last_hs = 1'b0;
         end else begin
            if (last_hs) chk("rd_done_after_last", rd_done, 1);
            last_hs = 1'b0;
            if (rd_done) n_rd_done++;
            if (cap_done) n_cap_done++;
            if (stall) chk("m_stable", {strm.m_valid, strm.m_last, strm.m_data}, stall_val);
            stall = strm.m_valid && !strm.m_ready;
            stall_val = {1'b1, strm.m_last, strm.m_data};
            if (ram_cea) begin
               if (exp_wr.size() == 0) miss("unexp_write");
               else begin
                  w = exp_wr.pop_front();
                  chk("ram_write", {ram_ada, ram_din}, w);
                  ref_mem[w[24:16]] = w[15:0];
               end
            end
            if (ram_ceb) begin
               outstanding++;
               chk("credit_le4", outstanding <= 4, 1);
               if (exp_rd.size() == 0) miss("unexp_read");
               else begin
                  a = exp_rd.pop_front();
                  chk("ram_read_addr", ram_adb, a);
               end
            end
            if (strm.m_valid && strm.m_ready) begin
               outstanding--;
               n_hs++;
               last_hs = strm.m_last;
               if (exp_out.size() == 0) miss("unexp_output");
               else begin
                  o = exp_out.pop_front();
                  chk("m_out", {strm.m_last, strm.m_data}, o);
               end
            end
         end
      end
   end
   // downstream ready pattern: 0 always ready, 1 one cycle in three, 2 random
   initial begin
      int ph;
      ph = 0;
      strm.m_ready = 1'b0;
      forever begin
         step();
         ph = (ph + 1) % 3;
         strm.m_ready = (m_mode == 0) ? 1'b1 : (m_mode == 1) ? (ph == 2) : 1'($urandom_range(0, 1));
      end
   end
   task automatic capture(input bit rnd, input bit with_rd, input int stop_at);
      cap_start = 1'b1;
      rd_start = with_rd;
      rd_offset = 9'd3;
      rd_len = 10'd5;
      step();
      cap_start = 1'b0;
      rd_start = 1'b0;
      chk("cap_busy", busy, 1);
      chk("cap_s_ready", strm.s_ready, 1);
      chk("cap_bufv_clr", buf_valid, 0);
      for (int k = 0; k < 512; k++) begin
         if (rnd && $urandom_range(0, 3) == 0) begin
            strm.s_valid = 1'b0;
            step();
         end
         if (k == stop_at) begin
            rst_n = 1'b0;
            #1;
            reset_chk("rst_mid_cap");
            strm.s_valid = 1'b0;
            exp_wr.delete();
            step();
            rst_n = 1'b1;
            return;
         end
         strm.s_valid = 1'b1;
         strm.s_data = rnd ? 16'($urandom) : 16'(k);
         exp_wr.push_back({9'(k), strm.s_data});
         step();
      end
      strm.s_valid = 1'b0;
      cap_exp++;
      chk("cap_done_pulse", cap_done, 1);
      chk("cap_buf_valid", buf_valid, 1);
      chk("cap_busy_fall", busy, 0);
      step();
      chk("cap_done_1cyc", cap_done, 0);
   endtask
   task automatic expect_window(input int off, input int len);
      for (int i = 0; i < len; i++) begin
         exp_rd.push_back(9'((off + i) % 512));
         exp_out.push_back({i == len - 1, ref_mem[(off + i) % 512]});
      end
   endtask
   task automatic run_window(input int off, input int len, input int mode, input bit restart);
      int d0, t;
      m_mode = mode;
      expect_window(off, len);
      d0 = n_rd_done;
      rd_offset = 9'(off);
      rd_len = 10'(len);
      rd_start = 1'b1;
      step();
      rd_start = 1'b0;
      rd_exp++;
      if (len == 0) begin
         chk("zero_rd_done", rd_done, 1);
         chk("zero_no_ceb", ram_ceb, 0);
         chk("zero_idle", {busy, strm.m_valid}, 0);
      end else begin
         chk("win_mvalid_e0", strm.m_valid, 0);
         step();
         chk("win_mvalid_e1", strm.m_valid, 0);
         step();
         chk("win_mvalid_e2", strm.m_valid, 1);
         if (restart) begin
            rd_offset = 9'((off + 77) % 512);
            rd_len = 10'd3;
            rd_start = 1'b1;
            step();
            rd_start = 1'b0;
         end
      end
      t = 0;
      while (n_rd_done == d0 && t < 6000) begin
         step();
         t++;
      end
      chk("win_rd_done_cnt", n_rd_done - d0, 1);
      chk("win_rd_q_empty", exp_rd.size(), 0);
      chk("win_out_q_empty", exp_out.size(), 0);
      chk("win_outstanding", outstanding, 0);
      chk("win_idle", busy, 0);
   endtask
   task automatic abort_window(input int off, input int len);
      int d0, h0, t;
      m_mode = 0;
      expect_window(off, len);
      d0 = n_rd_done;
      h0 = n_hs;
      rd_offset = 9'(off);
      rd_len = 10'(len);
      rd_start = 1'b1;
      step();
      rd_start = 1'b0;
      t = 0;
      while (n_hs - h0 < 3 && t < 100) begin
         step();
         t++;
      end
      chk("abort_reach3", n_hs - h0 >= 3, 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_mvalid", strm.m_valid, 0);
      chk("abort_idle", busy, 0);
      exp_rd.delete();
      exp_out.delete();
      outstanding = 0;
      repeat (5) step();
      chk("abort_no_done", n_rd_done - d0, 0);
      chk("abort_quiet", {strm.m_valid, ram_ceb}, 0);
   endtask
   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      rst_n = 1'b0;
      cap_start = 1'b0;
      rd_start = 1'b0;
      abort = 1'b0;
      rd_offset = '0;
      rd_len = '0;
      strm.s_valid = 1'b0;
      strm.s_data = '0;
      #12;
      reset_chk("reset");
      step();
      rst_n = 1'b1;
      step();
      capture(1'b0, 1'b0, -1);
      run_window(500, 20, 0, 1'b0);
      run_window(0, 512, 1, 1'b0);
      run_window(0, 0, 0, 1'b0);
      run_window(256, 512, 0, 1'b0);
      capture(1'b1, 1'b1, -1);
      repeat (3) step();
      run_window(10, 30, 2, 1'b1);
      abort_window(400, 20);
      for (int i = 0; i < 6; i++)
         run_window($urandom_range(0, 511), $urandom_range(0, 512), $urandom_range(0, 2), 1'b0);
      capture(1'b1, 1'b0, 100);
      chk("post_rst_bufv", buf_valid, 0);
      chk("post_rst_busy", busy, 0);
      capture(1'b1, 1'b0, -1);
      run_window($urandom_range(0, 511), $urandom_range(1, 512), 2, 1'b0);
      repeat (3) step();
      chk("total_rd_done", n_rd_done, rd_exp);
      chk("total_cap_done", n_cap_done, cap_exp);
      chk("wr_q_empty", exp_wr.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
